// File: rtl/mmio_ctrl_pkg.sv
// Shared constants and types for the memory-mapped I/O controller:
// data width, default decode addresses, pass magic and status FSM encoding.
package mmio_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEF_CONSOLE_ADDR    = 32'h1000_0000;
  localparam logic [XLEN-1:0] DEF_TEST_STAT_ADDR  = 32'h2000_0000;
  localparam logic [XLEN-1:0] DEF_TEST_PASS_MAGIC = 32'd123456789;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } stat_state_e;

  // Store strobe qualified by an exact word-address match.
  function automatic logic store_hit(input logic            we,
                                     input logic [XLEN-1:0] addr,
                                     input logic [XLEN-1:0] target);
    return we && (addr == target);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head reads as zero while empty.
// Pointers wrap modulo DEPTH, full/empty come from the count.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count and pointers define
  // validity, and leaving the array unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign head  = empty ? '0 : mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/mmio_ctrl.sv
// Routes datapath stores to dmem, the console FIFO or the test-status FSM,
// stalls on a full console FIFO, and reports completion once output drained.
module mmio_ctrl
  import mmio_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] CONSOLE_ADDR    = DEF_CONSOLE_ADDR,
  parameter logic [XLEN-1:0] TEST_STAT_ADDR  = DEF_TEST_STAT_ADDR,
  parameter logic [XLEN-1:0] TEST_PASS_MAGIC = DEF_TEST_PASS_MAGIC,
  parameter int              FIFO_DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [XLEN-1:0]               cpu_addr,
  input  logic [XLEN-1:0]               cpu_wdata,
  input  logic                          cpu_we,
  output logic                          cpu_stall,
  output logic [XLEN-1:0]               dmem_addr,
  output logic [XLEN-1:0]               dmem_wdata,
  output logic                          dmem_we,
  output logic [XLEN-1:0]               console_wdata,
  output logic                          console_valid,
  input  logic                          console_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          test_done,
  output logic                          test_passed
);

  logic        con_wr;
  logic        st_wr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;

  stat_state_e state_q;
  stat_state_e state_d;
  logic        pass_q;
  logic        pass_d;

  // Address decode; status and console writes never reach dmem.
  assign con_wr     = store_hit(cpu_we, cpu_addr, CONSOLE_ADDR);
  assign st_wr      = store_hit(cpu_we, cpu_addr, TEST_STAT_ADDR);
  assign dmem_we    = cpu_we && !con_wr && !st_wr;
  assign dmem_addr  = cpu_addr;
  assign dmem_wdata = dmem_we ? cpu_wdata : '0;

  // No pop bypass: a full FIFO stalls even while it is draining.
  assign cpu_stall     = con_wr && fifo_full;
  assign fifo_push     = con_wr && !fifo_full;
  assign fifo_pop      = console_valid && console_ready;
  assign console_valid = !fifo_empty;

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_console_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (cpu_wdata),
    .pop   (fifo_pop),
    .head  (console_wdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
    end
  end

  // NOTE: defaults assigned first so no path through the case leaves a
  // combinational output unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    unique case (state_q)
      ST_RUN: begin
        if (st_wr) begin
          pass_d  = (cpu_wdata == TEST_PASS_MAGIC);
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !fifo_push) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  assign test_done   = (state_q == ST_DONE);
  assign test_passed = pass_q && test_done;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl: console data checked against a scoreboard
// queue as it drains; decode, stall and status behaviour checked inline.
module tb_mmio_ctrl;
  import mmio_ctrl_pkg::*;

  localparam logic [31:0] CON  = 32'h1000_0000;
  localparam logic [31:0] STAT = 32'h2000_0000;
  localparam logic [31:0] MAGIC = 32'd123456789;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_we;
  logic        cpu_stall;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_we;
  logic [31:0] console_wdata;
  logic        console_valid;
  logic        console_ready;
  logic [3:0]  fifo_count;
  logic        test_done, test_passed;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mmio_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_we        (cpu_we),
    .cpu_stall     (cpu_stall),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_we       (dmem_we),
    .console_wdata (console_wdata),
    .console_valid (console_valid),
    .console_ready (console_ready),
    .fifo_count    (fifo_count),
    .test_done     (test_done),
    .test_passed   (test_passed)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    cpu_we    = 1'b1;
    cpu_addr  = addr;
    cpu_wdata = data;
    if (addr == CON) exp_q.push_back(data);
    #1;
  endtask

  task automatic idle();
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
  endtask

  // Inputs only change just after posedge, so negedge sees what the next edge pops.
  always @(negedge clk) begin
    if (!reset && console_valid && console_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL console_extra: observed=%0h expected=none", console_wdata);
      end else begin
        check("console_data", console_wdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    console_ready = 1'b0;
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_valid", 32'(console_valid), 32'd0);
    check("rst_cdata", console_wdata, 32'd0);
    check("rst_done", 32'(test_done), 32'd0);
    check("rst_passed", 32'(test_passed), 32'd0);

    // Single console byte with the console ready.
    console_ready = 1'b1;
    store(CON, 32'h41);
    check("con_no_dmem", 32'(dmem_we), 32'd0);
    check("con_no_stall", 32'(cpu_stall), 32'd0);
    tick();
    idle();
    check("con_valid_n1", 32'(console_valid), 32'd1);
    check("con_data_n1", console_wdata, 32'h41);
    tick();
    check("con_drained", 32'(fifo_count), 32'd0);

    // Fill to depth, ninth store stalls until the first pop.
    console_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      store(CON, 32'(i));
      check("fill_no_stall", 32'(cpu_stall), 32'd0);
      tick();
    end
    store(CON, 32'd9);
    check("full_count", 32'(fifo_count), 32'd8);
    check("full_stall", 32'(cpu_stall), 32'd1);
    tick();
    check("hold_stall", 32'(cpu_stall), 32'd1);
    check("hold_count", 32'(fifo_count), 32'd8);
    console_ready = 1'b1;
    #1;
    check("pop_cycle_stall", 32'(cpu_stall), 32'd1);
    tick();
    check("after_pop_stall", 32'(cpu_stall), 32'd0);
    check("after_pop_count", 32'(fifo_count), 32'd7);
    tick();
    idle();
    check("push_pop_count", 32'(fifo_count), 32'd7);
    for (int k = 0; k < 30 && fifo_count != 0; k++) tick();
    check("drain9_count", 32'(fifo_count), 32'd0);
    check("drain9_queue", 32'(exp_q.size()), 32'd0);

    // Pass status with an empty FIFO, then dmem and ignored status writes.
    store(STAT, MAGIC);
    check("stat_no_dmem", 32'(dmem_we), 32'd0);
    tick();
    idle();
    check("drain_not_done", 32'(test_done), 32'd0);
    tick();
    check("pass_done", 32'(test_done), 32'd1);
    check("pass_passed", 32'(test_passed), 32'd1);
    store(STAT, 32'd5);
    check("stat2_no_dmem", 32'(dmem_we), 32'd0);
    tick();
    idle();
    check("stat2_passed", 32'(test_passed), 32'd1);
    check("stat2_done", 32'(test_done), 32'd1);
    store(32'h0000_0100, 32'hDEAD_BEEF);
    check("dmem_we", 32'(dmem_we), 32'd1);
    check("dmem_wdata", dmem_wdata, 32'hDEAD_BEEF);
    check("dmem_addr", dmem_addr, 32'h0000_0100);
    tick();
    idle();
    #1;
    check("dmem_idle_wdata", dmem_wdata, 32'd0);
    check("dmem_no_fifo", 32'(fifo_count), 32'd0);

    // Failing status value.
    do_reset();
    store(STAT, 32'd5);
    tick();
    idle();
    tick();
    check("fail_done", 32'(test_done), 32'd1);
    check("fail_passed", 32'(test_passed), 32'd0);

    // Status write waits for pending console output.
    do_reset();
    console_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      store(CON, 32'hA0 + 32'(i));
      tick();
    end
    store(STAT, MAGIC);
    tick();
    idle();
    tick();
    tick();
    check("pend_not_done", 32'(test_done), 32'd0);
    check("pend_count", 32'(fifo_count), 32'd3);
    console_ready = 1'b1;
    for (int k = 0; k < 20 && fifo_count != 0; k++) begin
      check("pend_wait_done", 32'(test_done), 32'd0);
      tick();
    end
    check("pend_empty", 32'(fifo_count), 32'd0);
    tick();
    check("pend_done", 32'(test_done), 32'd1);
    check("pend_passed", 32'(test_passed), 32'd1);
    check("pend_queue", 32'(exp_q.size()), 32'd0);

    // Reset while draining with queued data.
    do_reset();
    console_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      store(CON, 32'hB0 + 32'(i));
      tick();
    end
    store(STAT, MAGIC);
    tick();
    idle();
    check("pre_rst_count", 32'(fifo_count), 32'd4);
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_valid", 32'(console_valid), 32'd0);
    check("mid_rst_done", 32'(test_done), 32'd0);
    tick();
    tick();
    check("post_rst_done", 32'(test_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
